// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer peripheral on the 16-bit data port: prescaled compare/overflow
// counter, free-running cycle counter, coherent 32-bit reads and a level compare interrupt.
module mmio_timer #(
   parameter int unsigned PORT_LEN       = 16,
   parameter int unsigned RESET_PRESCALE = 0
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic                select_i,
   input  logic                write_i,
   input  logic                read_i,
   input  logic [4:0]          addr_i,
   input  logic [PORT_LEN-1:0] data_i,
   input  logic [PORT_LEN-1:0] mask_i,
   output logic [PORT_LEN-1:0] data_o,
   output logic                irq_o
);

   localparam int unsigned DW = PORT_LEN;
   localparam int unsigned CW = 2 * PORT_LEN;

   localparam logic [3:0] IDX_CTRL     = 4'd0;
   localparam logic [3:0] IDX_STATUS   = 4'd1;
   localparam logic [3:0] IDX_PRESCALE = 4'd2;
   localparam logic [3:0] IDX_COUNT_LO = 4'd4;
   localparam logic [3:0] IDX_COUNT_HI = 4'd5;
   localparam logic [3:0] IDX_CMP_LO   = 4'd6;
   localparam logic [3:0] IDX_CMP_HI   = 4'd7;
   localparam logic [3:0] IDX_CYCLE_LO = 4'd8;
   localparam logic [3:0] IDX_CYCLE_HI = 4'd9;

   // ctrl: [0] EN, [1] AUTORELOAD, [2] IRQEN; status: [0] MATCH, [1] OVF
   logic [2:0]    ctrl;
   logic [1:0]    status;
   logic [DW-1:0] prescale;
   logic [DW-1:0] pre;
   logic [CW-1:0] count;
   logic [CW-1:0] cmp;
   logic [CW-1:0] cycle;
   logic [DW-1:0] count_shadow;
   logic [DW-1:0] cycle_shadow;

   logic [3:0]    idx;
   logic          wr_c;
   logic          rd_c;
   logic          tick_c;
   logic          match_c;
   logic          ovf_c;
   logic [DW-1:0] wdata_c;
   logic [DW-1:0] rdata_c;
   logic [1:0]    clr_c;
   logic [CW-1:0] count_inc_c;
   logic [CW-1:0] count_tick_c;
   logic [CW-1:0] count_nxt_c;
   logic [CW-1:0] cmp_nxt_c;
   logic [DW-1:0] prescale_nxt_c;
   logic [DW-1:0] pre_nxt_c;
   logic [2:0]    ctrl_nxt_c;
   logic [1:0]    status_nxt_c;

   logic          unused_addr;
   assign unused_addr = addr_i[0];

   // Tick generation, counter update and masked register writes
   always_comb begin
      idx         = addr_i[4:1];
      wr_c        = select_i & write_i;
      rd_c        = select_i & read_i;
      wdata_c     = data_i & mask_i;
      tick_c      = ctrl[0] && (pre == prescale);
      count_inc_c = count + CW'(1);
      match_c     = tick_c && (count == cmp);
      ovf_c       = tick_c && !match_c && (count_inc_c == '0);

      count_tick_c = count;
      if (match_c && ctrl[1]) begin
         count_tick_c = '0;
      end else if (tick_c) begin
         count_tick_c = count_inc_c;
      end

      pre_nxt_c = '0;
      if (ctrl[0] && !tick_c) begin
         pre_nxt_c = pre + DW'(1);
      end

      ctrl_nxt_c     = ctrl;
      clr_c          = '0;
      prescale_nxt_c = prescale;
      count_nxt_c    = count_tick_c;
      cmp_nxt_c      = cmp;
      if (wr_c) begin
         case (idx)
            IDX_CTRL:     ctrl_nxt_c = (ctrl & ~mask_i[2:0]) | wdata_c[2:0];
            IDX_STATUS:   clr_c = wdata_c[1:0];
            IDX_PRESCALE: prescale_nxt_c = (prescale & ~mask_i) | wdata_c;
            IDX_COUNT_LO: count_nxt_c[DW-1:0] = (count_tick_c[DW-1:0] & ~mask_i) | wdata_c;
            IDX_COUNT_HI: count_nxt_c[CW-1:DW] = (count_tick_c[CW-1:DW] & ~mask_i) | wdata_c;
            IDX_CMP_LO:   cmp_nxt_c[DW-1:0] = (cmp[DW-1:0] & ~mask_i) | wdata_c;
            IDX_CMP_HI:   cmp_nxt_c[CW-1:DW] = (cmp[CW-1:DW] & ~mask_i) | wdata_c;
            default:      ;
         endcase
      end
      // a set event in the same cycle as its W1C keeps the bit high
      status_nxt_c = (status & ~clr_c) | {ovf_c, match_c};
   end

   // Read mux over the pre-write register values
   always_comb begin
      rdata_c = '0;
      case (idx)
         IDX_CTRL:     rdata_c = DW'(ctrl);
         IDX_STATUS:   rdata_c = DW'(status);
         IDX_PRESCALE: rdata_c = prescale;
         IDX_COUNT_LO: rdata_c = count[DW-1:0];
         IDX_COUNT_HI: rdata_c = count_shadow;
         IDX_CMP_LO:   rdata_c = cmp[DW-1:0];
         IDX_CMP_HI:   rdata_c = cmp[CW-1:DW];
         IDX_CYCLE_LO: rdata_c = cycle[DW-1:0];
         IDX_CYCLE_HI: rdata_c = cycle_shadow;
         default:      rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ctrl         <= '0;
         status       <= '0;
         prescale     <= DW'(RESET_PRESCALE);
         pre          <= '0;
         count        <= '0;
         cmp          <= '1;
         cycle        <= '0;
         count_shadow <= '0;
         cycle_shadow <= '0;
         data_o       <= '0;
      end else begin
         ctrl     <= ctrl_nxt_c;
         status   <= status_nxt_c;
         prescale <= prescale_nxt_c;
         pre      <= pre_nxt_c;
         count    <= count_nxt_c;
         cmp      <= cmp_nxt_c;
         cycle    <= cycle + CW'(1);
         if (rd_c) begin
            data_o <= rdata_c;
            if (idx == IDX_COUNT_LO) count_shadow <= count[CW-1:DW];
            if (idx == IDX_CYCLE_LO) cycle_shadow <= cycle[CW-1:DW];
         end
      end
   end

   assign irq_o = ctrl[2] & status[0];

endmodule
